// File: rtl/rs_seg_adder_pipe.sv
// Segmented WIDTH-bit add/sub with a registered inter-segment carry; NSEG-cycle latency.
// Global stall: every register advances only when out_valid is low or out_ready is high.
module rs_seg_adder_pipe #(
    parameter int WIDTH = 64,
    parameter int SEG   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_ci,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_co,
    output logic             out_ovf
);
    localparam int NSEG = (WIDTH + SEG - 1) / SEG;
    localparam int LAST = WIDTH - (NSEG - 1) * SEG;

    logic en;
    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    logic             cap_vld_q;
    logic             cap_ci_q;
    logic [WIDTH-1:0] cap_a_q;
    logic [WIDTH-1:0] cap_b_q;

    // B is conditioned once at capture so every stage sees a plain add.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_vld_q <= 1'b0;
            cap_ci_q  <= 1'b0;
            cap_a_q   <= '0;
            cap_b_q   <= '0;
        end else if (en) begin
            cap_vld_q <= in_valid;
            cap_ci_q  <= in_ci;
            cap_a_q   <= in_a;
            cap_b_q   <= in_sub ? ~in_b : in_b;
        end
    end

    for (genvar k = 0; k < NSEG; k++) begin : stg
        localparam int LOW = k * SEG;
        localparam int SW  = (k == NSEG - 1) ? LAST : SEG;
        localparam int INW = WIDTH - LOW;

        logic [INW-1:0]    op_a;
        logic [INW-1:0]    op_b;
        logic              v_in;
        logic              c_in;
        logic [SW:0]       seg_add;
        logic [LOW+SW-1:0] sum_d;
        logic              v_q;
        logic              c_q;
        logic [LOW+SW-1:0] sum_q;

        if (k == 0) begin : src
            assign op_a  = cap_a_q;
            assign op_b  = cap_b_q;
            assign v_in  = cap_vld_q;
            assign c_in  = cap_ci_q;
            assign sum_d = seg_add[SW-1:0];
        end else begin : src
            assign op_a  = stg[k-1].fwd.a_q;
            assign op_b  = stg[k-1].fwd.b_q;
            assign v_in  = stg[k-1].v_q;
            assign c_in  = stg[k-1].c_q;
            assign sum_d = {seg_add[SW-1:0], stg[k-1].sum_q};
        end

        assign seg_add = {1'b0, op_a[SW-1:0]} + {1'b0, op_b[SW-1:0]} + {{SW{1'b0}}, c_in};

        // Finished low segments ride along as the de-skew line for this beat.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                sum_q <= '0;
            end else if (en) begin
                v_q   <= v_in;
                c_q   <= seg_add[SW];
                sum_q <= sum_d;
            end
        end

        if (k < NSEG - 1) begin : fwd
            logic [INW-SW-1:0] a_q;
            logic [INW-SW-1:0] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    a_q <= op_a[INW-1:SW];
                    b_q <= op_b[INW-1:SW];
                end
            end
        end else begin : last
            logic ovf_q;

            // a^b^sum at the MSB recovers the carry into the MSB.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (en) begin
                    ovf_q <= op_a[SW-1] ^ op_b[SW-1] ^ seg_add[SW-1] ^ seg_add[SW];
                end
            end
        end
    end

    assign out_valid = stg[NSEG-1].v_q;
    assign out_co    = stg[NSEG-1].c_q;
    assign out_sum   = stg[NSEG-1].sum_q;
    assign out_ovf   = stg[NSEG-1].last.ovf_q;

endmodule

// File: tb/tb_rs_seg_adder_pipe.sv
// Bench for rs_seg_adder_pipe: directed vectors on 64/16 and 40/16 instances plus a stalled random stream.
module tb_rs_seg_adder_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    int          checks = 0;
    int          errors = 0;

    logic        v64, rdy64, ci64, sub64, ov64, ordy64, co64, ovf64;
    logic [63:0] a64, b64, s64;
    logic        v40, rdy40, ci40, sub40, ov40, ordy40, co40, ovf40;
    logic [39:0] a40, b40, s40;

    rs_seg_adder_pipe #(.WIDTH(64), .SEG(16)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(v64), .in_ready(rdy64),
        .in_a(a64), .in_b(b64), .in_ci(ci64), .in_sub(sub64),
        .out_valid(ov64), .out_ready(ordy64), .out_sum(s64), .out_co(co64), .out_ovf(ovf64)
    );

    rs_seg_adder_pipe #(.WIDTH(40), .SEG(16)) dut40 (
        .clk(clk), .rst_n(rst_n), .in_valid(v40), .in_ready(rdy40),
        .in_a(a40), .in_b(b40), .in_ci(ci40), .in_sub(sub40),
        .out_valid(ov40), .out_ready(ordy40), .out_sum(s40), .out_co(co40), .out_ovf(ovf40)
    );

    function automatic logic [65:0] model64(input logic [63:0] a, input logic [63:0] b,
                                            input logic ci, input logic sub);
        logic [63:0] bb;
        logic [64:0] s;
        logic        ovf;
        bb  = sub ? ~b : b;
        s   = {1'b0, a} + {1'b0, bb} + {64'd0, ci};
        ovf = (a[63] == bb[63]) && (s[63] != a[63]);
        return {ovf, s[64], s[63:0]};
    endfunction

    task automatic run64(input logic [63:0] a, input logic [63:0] b, input logic ci, input logic sub,
                         output int lat, output logic [63:0] s, output logic co, output logic ovf);
        lat = -1; s = '0; co = 1'b0; ovf = 1'b0;
        @(posedge clk); #1;
        v64 = 1'b1; a64 = a; b64 = b; ci64 = ci; sub64 = sub; ordy64 = 1'b1;
        @(posedge clk); #1;
        v64 = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (ov64) begin
                lat = c; s = s64; co = co64; ovf = ovf64;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        v64 = 0; a64 = '0; b64 = '0; ci64 = 0; sub64 = 0; ordy64 = 1;
        v40 = 0; a40 = '0; b40 = '0; ci40 = 0; sub40 = 0; ordy40 = 1;
        #2;
        checks++;
        if ({ov64, s64, co64, ovf64, rdy64} !== {1'b0, 64'd0, 1'b0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL reset64_in: got v=%b s=%h co=%b ovf=%b rdy=%b want 0/0/0/0/1",
                               ov64, s64, co64, ovf64, rdy64);
        end
        checks++;
        if ({ov40, s40, co40, ovf40, rdy40} !== {1'b0, 40'd0, 1'b0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL reset40_in: got v=%b s=%h co=%b ovf=%b rdy=%b want 0/0/0/0/1",
                               ov40, s40, co40, ovf40, rdy40);
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({ov64, s64, rdy64, ov40, rdy40} !== {1'b0, 64'd0, 1'b1, 1'b0, 1'b1}) begin
            errors++; $display("FAIL reset_release: got v64=%b s64=%h rdy64=%b v40=%b rdy40=%b want 0/0/1/0/1",
                               ov64, s64, rdy64, ov40, rdy40);
        end
    endtask

    task automatic test_add_carry();
        int lat; logic [63:0] s; logic co, ovf;
        run64(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, lat, s, co, ovf);
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL add_latency: got %0d want 4", lat); end
        checks++;
        if ({s, co, ovf} !== {64'd0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL add_wrap: got s=%h co=%b ovf=%b want 0/1/0", s, co, ovf);
        end
    endtask

    task automatic test_sub();
        int lat; logic [63:0] s; logic co, ovf;
        run64(64'd0, 64'd1, 1'b1, 1'b1, lat, s, co, ovf);
        checks++;
        if (lat !== 4 || {s, co, ovf} !== {64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0}) begin
            errors++; $display("FAIL sub_0_minus_1: got lat=%0d s=%h co=%b ovf=%b want 4/ffffffffffffffff/0/0",
                               lat, s, co, ovf);
        end
    endtask

    task automatic test_overflow();
        int lat; logic [63:0] s; logic co, ovf;
        run64(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, lat, s, co, ovf);
        checks++;
        if (lat !== 4 || {s, co, ovf} !== {64'h8000_0000_0000_0000, 1'b0, 1'b1}) begin
            errors++; $display("FAIL signed_ovf: got lat=%0d s=%h co=%b ovf=%b want 4/8000000000000000/0/1",
                               lat, s, co, ovf);
        end
    endtask

    task automatic test_w40();
        int lat;
        lat = -1;
        @(posedge clk); #1;
        v40 = 1'b1; a40 = 40'h00_FFFF_FFFF; b40 = 40'd1; ci40 = 0; sub40 = 0; ordy40 = 1;
        @(posedge clk); #1;
        v40 = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (ov40) begin lat = c; break; end
        end
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL w40_latency: got %0d want 3", lat); end
        checks++;
        if ({s40, co40, ovf40} !== {40'h01_0000_0000, 1'b0, 1'b0}) begin
            errors++; $display("FAIL w40_carry: got s=%h co=%b ovf=%b want 0100000000/0/0", s40, co40, ovf40);
        end
    endtask

    task automatic test_stream();
        logic [65:0] exp_q[$];
        logic [65:0] held, want;
        logic        stall_prev;
        int          acc, emit;
        acc = 0; emit = 0; stall_prev = 1'b0; held = '0;
        for (int cyc = 0; cyc < 20000 && (acc < 1000 || exp_q.size() > 0); cyc++) begin
            @(posedge clk); #1;
            if (acc < 1000) begin
                v64   = ($urandom_range(0, 3) != 0);
                a64   = {$urandom, $urandom};
                b64   = {$urandom, $urandom};
                ci64  = $urandom_range(0, 1);
                sub64 = $urandom_range(0, 1);
            end else begin
                v64 = 1'b0;
            end
            ordy64 = (acc >= 1000) ? 1'b1 : ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (stall_prev) begin
                checks++;
                if (ov64 !== 1'b1 || {ovf64, co64, s64} !== held) begin
                    errors++; $display("FAIL stall_hold: got v=%b %h want v=1 %h", ov64, {ovf64, co64, s64}, held);
                end
            end
            if (ordy64) begin
                checks++;
                if (rdy64 !== 1'b1) begin errors++; $display("FAIL throughput_rdy: got in_ready=%b want 1", rdy64); end
            end
            if (ov64 && ordy64) begin
                emit++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL stream_extra: got unexpected result %h want none", {ovf64, co64, s64});
                end else begin
                    want = exp_q.pop_front();
                    if ({ovf64, co64, s64} !== want) begin
                        errors++; $display("FAIL stream_data: got %h want %h", {ovf64, co64, s64}, want);
                    end
                end
            end
            if (v64 && rdy64) begin
                exp_q.push_back(model64(a64, b64, ci64, sub64));
                acc++;
            end
            stall_prev = ov64 && !ordy64;
            held       = {ovf64, co64, s64};
        end
        checks++;
        if (acc != 1000 || emit != 1000 || exp_q.size() != 0) begin
            errors++; $display("FAIL stream_count: got acc=%0d emit=%0d left=%0d want 1000/1000/0",
                               acc, emit, exp_q.size());
        end
    endtask

    task automatic test_reset_midflight();
        int lat, seen, waited; logic [63:0] s; logic co, ovf;
        seen = 0; waited = -1;
        @(posedge clk); #1;
        ordy64 = 1'b0; v64 = 1'b1; ci64 = 0; sub64 = 0; b64 = 64'd1;
        for (int i = 0; i < 3; i++) begin
            a64 = 64'h1111 * (i + 1);
            @(posedge clk); #1;
        end
        v64 = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (ov64) begin waited = c; break; end
            @(posedge clk); #1;
        end
        checks++;
        if (waited < 0) begin errors++; $display("FAIL midflight_fill: got no out_valid want 1"); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ov64, s64, co64, ovf64, rdy64} !== {1'b0, 64'd0, 1'b0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL midflight_clear: got v=%b s=%h co=%b ovf=%b rdy=%b want 0/0/0/0/1",
                               ov64, s64, co64, ovf64, rdy64);
        end
        #3 rst_n = 1'b1;
        ordy64 = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (ov64) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL midflight_ghost: got %0d stale beats want 0", seen); end
        run64(64'd5, 64'd3, 1'b0, 1'b0, lat, s, co, ovf);
        checks++;
        if (lat !== 4 || {s, co, ovf} !== {64'd8, 1'b0, 1'b0}) begin
            errors++; $display("FAIL midflight_after: got lat=%0d s=%h co=%b ovf=%b want 4/8/0/0", lat, s, co, ovf);
        end
    endtask

    initial begin
        test_reset();
        test_add_carry();
        test_sub();
        test_overflow();
        test_w40();
        test_stream();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
